imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the processor's instruction memory. Accepts a framed byte stream (header, payload, checksum) on a valid/ready interface. Assembles little-endian 32-bit words and writes them sequentially into instruction memory from word address 0. Holds the processor in reset until a complete frame with a correct checksum has been loaded.

---
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the instruction memory.
//
// Accepts a framed byte stream on a valid/ready interface:
//   header byte N (word count, 1..DEPTH_WORDS), 4*N payload bytes (LSB first per word),
//   then one checksum byte equal to the XOR of all payload bytes.
// Assembled 32-bit words are written sequentially from word address 0. The processor is
// held in reset (core_rst_o low) until a complete frame with a matching checksum is loaded.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       begin a load (honoured only when idle, done or in error)
//   in_valid_i    byte-stream valid
//   in_data_i     byte-stream data
//   in_ready_o    loader accepts a byte this cycle (pure state decode)
//   imem_we_o     instruction memory write strobe, one cycle per word
//   imem_addr_o   instruction memory word address
//   imem_wdata_o  instruction word
//   core_rst_o    active-low processor reset, released only after a good load
//   busy_o        load in progress
//   done_o        last load succeeded
//   err_o         last load failed
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          n_q, n_d;          // frame word count from the header
  logic [CntW-1:0]     wcnt_q, wcnt_d;    // words written so far
  logic [1:0]          bcnt_q, bcnt_d;    // byte position within the current word
  logic [7:0]          acc_q, acc_d;      // running XOR of payload bytes
  logic [23:0]         wbuf_q, wbuf_d;    // bytes 0..2 of the word being assembled
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic accept;
  logic hdr_bad;
  logic last_word;

  // Outputs are decodes of registered state, so they never depend on in_valid_i.
  assign in_ready_o   = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
  assign busy_o       = in_ready_o;
  assign done_o       = (state_q == StDone);
  assign err_o        = (state_q == StErr);
  assign core_rst_o   = (state_q == StDone);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;

  assign accept    = in_valid_i && in_ready_o;
  assign hdr_bad   = (in_data_i == 8'd0) || (32'(in_data_i) > DEPTH_WORDS);
  // The word completing now is the final one of the frame.
  assign last_word = (32'(wcnt_q) + 32'd1) == 32'(n_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StHdr;
        end
      end

      StHdr: begin
        if (accept) begin
          if (hdr_bad) begin
            state_d = StErr;
          end else begin
            n_d     = in_data_i;
            wcnt_d  = '0;
            bcnt_d  = '0;
            acc_d   = '0;
            state_d = StData;
          end
        end
      end

      StData: begin
        if (accept) begin
          acc_d  = acc_q ^ in_data_i;
          bcnt_d = bcnt_q + 2'd1;
          unique case (bcnt_q)
            2'd0: wbuf_d[7:0]   = in_data_i;
            2'd1: wbuf_d[15:8]  = in_data_i;
            2'd2: wbuf_d[23:16] = in_data_i;
            2'd3: begin
              // Byte 3 goes straight into the write register alongside the buffered bytes.
              we_d    = 1'b1;
              addr_d  = wcnt_q[ADDR_W-1:0];
              wdata_d = {in_data_i, wbuf_q};
              wcnt_d  = wcnt_q + 1'b1;
              if (last_word) begin
                state_d = StCsum;
              end
            end
            default: ;
          endcase
        end
      end

      StCsum: begin
        if (accept) begin
          state_d = (in_data_i == acc_q) ? StDone : StErr;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      n_q     <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset values, nominal load, bad checksum,
// header bounds, full-depth load, gapped stream and reset in the middle of a load.
module tb_imem_loader;

  localparam int unsigned Depth = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(
    .DEPTH_WORDS(Depth),
    .ADDR_W     (AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .core_rst_o  (core_rst),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]    frame[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            cyc_cnt = 0;
  int            max_addr = 0;
  int            t0 = 0;
  int            base = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Write-port monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      if (int'(imem_addr) > max_addr) max_addr = int'(imem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the loader in HDR.
  task automatic do_start();
    start = 1'b1;
    t0 = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams the bytes in 'frame'; gapped drops in_valid at random and drives junk data.
  task automatic send_frame(input bit gapped);
    int   idx = 0;
    int   guard = 0;
    logic v;
    logic acc;
    while (idx < frame.size() && guard < 4000) begin
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? frame[idx] : 8'($urandom);
      acc = v && in_ready;
      @(negedge clk);
      guard++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("frame_accepted", 32'(idx), 32'(frame.size()));
  endtask

  // Payload 13 00 00 00 93 00 10 00 -> words 0x00000013, 0x00100093; XOR of payload is 0x90.
  task automatic set_nominal(input logic [7:0] csum);
    frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, csum};
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base >= 2) begin
      check({tag, "_a0"}, 32'(wr_addr[base]), 32'd0);
      check({tag, "_d0"}, wr_data[base], 32'h0000_0013);
      check({tag, "_a1"}, 32'(wr_addr[base+1]), 32'd1);
      check({tag, "_d1"}, wr_data[base+1], 32'h0010_0093);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] w;

    // Reset held with active inputs: every output must stay low.
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hff;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal N=2, checksum byte held back to observe timing around it.
    base = wr_addr.size();
    do_start();
    check("hdr_ready", 32'(in_ready), 32'd1);
    frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(1'b0);
    check("nom_last_we", 32'(imem_we), 32'd1);
    check("nom_pre_core_rst", 32'(core_rst), 32'd0);
    check("nom_pre_busy", 32'(busy), 32'd1);
    frame = '{8'h90};
    send_frame(1'b0);
    check("nom_latency", 32'(cyc_cnt - t0), 32'd11);
    check("nom_done", 32'(done), 32'd1);
    check("nom_core_rst", 32'(core_rst), 32'd1);
    check("nom_err", 32'(err), 32'd0);
    check("nom_in_ready", 32'(in_ready), 32'd0);
    check_two_words("nom");

    // Bad checksum: words still land, core stays in reset.
    base = wr_addr.size();
    do_start();
    check("reload_done_low", 32'(done), 32'd0);
    check("reload_core_rst", 32'(core_rst), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    set_nominal(8'h81);
    send_frame(1'b0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_core_rst", 32'(core_rst), 32'd0);
    check_two_words("bad");
    do_start();
    check("restart_err_low", 32'(err), 32'd0);
    set_nominal(8'h90);
    send_frame(1'b0);
    check("recover_done", 32'(done), 32'd1);

    // Header N=0.
    base = wr_addr.size();
    do_start();
    frame = '{8'h00};
    send_frame(1'b0);
    check("n0_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("n0_nwr", 32'(wr_addr.size() - base), 32'd0);
    check("n0_stays_err", 32'(err), 32'd1);

    // Header N=DEPTH+1.
    do_start();
    frame = '{8'd65};
    send_frame(1'b0);
    check("n65_err", 32'(err), 32'd1);
    check("n65_nwr", 32'(wr_addr.size() - base), 32'd0);

    // Full-depth load, N=DEPTH.
    base = wr_addr.size();
    max_addr = 0;
    frame.delete();
    frame.push_back(8'd64);
    cs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) begin
        unique case (k)
          0: b = 8'(i);
          1: b = ~8'(i);
          2: b = 8'(i) ^ 8'h5a;
          default: b = 8'hc3;
        endcase
        frame.push_back(b);
        cs = cs ^ b;
      end
    end
    frame.push_back(cs);
    do_start();
    send_frame(1'b0);
    check("full_done", 32'(done), 32'd1);
    check("full_nwr", 32'(wr_addr.size() - base), 32'd64);
    check("full_max_addr", 32'(max_addr), 32'd63);
    if (wr_addr.size() - base == 64) begin
      for (int i = 0; i < 64; i++) begin
        w = {8'hc3, 8'(i) ^ 8'h5a, ~8'(i), 8'(i)};
        check($sformatf("full_a%0d", i), 32'(wr_addr[base+i]), 32'(i));
        check($sformatf("full_d%0d", i), wr_data[base+i], w);
      end
    end

    // Gapped stream with junk data on idle cycles.
    base = wr_addr.size();
    do_start();
    set_nominal(8'h90);
    send_frame(1'b1);
    check("gap_done", 32'(done), 32'd1);
    check("gap_err", 32'(err), 32'd0);
    check_two_words("gap");

    // Reset after five payload bytes.
    do_start();
    frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    send_frame(1'b0);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_we", 32'(imem_we), 32'd0);
    check("mid_addr", 32'(imem_addr), 32'd0);
    check("mid_wdata", imem_wdata, 32'd0);
    check("mid_core_rst", 32'(core_rst), 32'd0);
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h00;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    base = wr_addr.size();
    do_start();
    set_nominal(8'h90);
    send_frame(1'b0);
    check("post_rst_done", 32'(done), 32'd1);
    check_two_words("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
